plru_way_selector: RTL and testbench

- Per-set tree pseudo-LRU replacement engine for the L2 model.
- Accepts one access per handshake: set index, hit flag, one-hot hit vector. Returns a binary way index: the encoded hit way on a hit, the PLRU victim on a miss.
- Updates that set's PLRU state on every accepted access.
- Replaces the standalone combinational one-hot encoder path. Adds registered output, backpressure, hazard-free state and a flush sweep.

---
 rtl/plru_pkg.sv | 72 +++++++
 rtl/onehot_encoder.sv | 31 +++
 rtl/plru_way_selector.sv | 179 +++++++++++++++++
 tb/tb_plru_way_selector.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/plru_pkg.sv
`default_nettype none
// ============================================================================
// Module : plru_pkg
// Brief  : Shared widths, FSM state type and tree-PLRU helper functions.
// Rev    : 1.0  initial release
// ============================================================================
package plru_pkg;

    localparam int PLRU_WAYS      = 8;
    localparam int PLRU_SETS      = 16;
    localparam int PLRU_WAY_W     = $clog2(PLRU_WAYS);
    localparam int PLRU_SET_W     = $clog2(PLRU_SETS);

    // Helpers work on a maximum-size tree so any WAYS up to 64 can share them.
    localparam int PLRU_MAX_WAY_W = 6;
    localparam int PLRU_MAX_NODES = (1 << PLRU_MAX_WAY_W) - 1;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } plru_state_e;

    // Heap-ordered walk: bit 0 goes left, 1 goes right; path bits form the way.
    function automatic logic [PLRU_MAX_WAY_W-1:0] plru_victim(
        input logic [PLRU_MAX_NODES-1:0] tree,
        input int unsigned               levels
    );
        logic [PLRU_MAX_WAY_W-1:0] way;
        logic [PLRU_MAX_WAY_W-1:0] node;
        logic                      b;
        way  = '0;
        node = '0;
        for (int unsigned lvl = 0; lvl < PLRU_MAX_WAY_W; lvl++) begin
            if (lvl < levels) begin
                b    = tree[node];
                way  = {way[PLRU_MAX_WAY_W-2:0], b};
                node = {node[PLRU_MAX_WAY_W-2:0], 1'b0}
                     + {{(PLRU_MAX_WAY_W-1){1'b0}}, 1'b1}
                     + {{(PLRU_MAX_WAY_W-1){1'b0}}, b};
            end
        end
        return way;
    endfunction

    // Every node on the path to 'way' is made to point at the other subtree.
    function automatic logic [PLRU_MAX_NODES-1:0] plru_touch(
        input logic [PLRU_MAX_NODES-1:0] tree,
        input logic [PLRU_MAX_WAY_W-1:0] way,
        input int unsigned               levels
    );
        logic [PLRU_MAX_NODES-1:0] t;
        logic [PLRU_MAX_WAY_W-1:0] w;
        logic [PLRU_MAX_WAY_W-1:0] node;
        logic                      b;
        t    = tree;
        w    = way << (PLRU_MAX_WAY_W - levels);
        node = '0;
        for (int unsigned lvl = 0; lvl < PLRU_MAX_WAY_W; lvl++) begin
            if (lvl < levels) begin
                b       = w[PLRU_MAX_WAY_W-1];
                t[node] = ~b;
                node    = {node[PLRU_MAX_WAY_W-2:0], 1'b0}
                        + {{(PLRU_MAX_WAY_W-1){1'b0}}, 1'b1}
                        + {{(PLRU_MAX_WAY_W-1){1'b0}}, b};
                w       = w << 1;
            end
        end
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_encoder.sv
`default_nettype none
// ============================================================================
// Module : onehot_encoder
// Brief  : One-hot to binary encoder; err flags popcount != 1.
// Rev    : 1.0  initial release
// ============================================================================
module onehot_encoder #(
    parameter  int WAYS  = 8,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-1:0]  vec,
    output logic [WAY_W-1:0] idx,
    output logic             err
);

    logic [WAY_W:0] w_cnt;

    always_comb begin
        idx   = '0;
        w_cnt = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (vec[i]) begin
                idx   = idx | WAY_W'(i);
                w_cnt = w_cnt + (WAY_W+1)'(1);
            end
        end
        err = (w_cnt != (WAY_W+1)'(1));
    end

endmodule
`default_nettype wire

// File: rtl/plru_way_selector.sv
`default_nettype none
// ============================================================================
// Module : plru_way_selector
// Brief  : Per-set tree pseudo-LRU way selector with registered response.
//          Optional hit/miss counters enabled by macro PLRU_STATS_EN.
// Rev    : 1.0  initial release
// ============================================================================
module plru_way_selector
    import plru_pkg::*;
#(
    parameter  int WAYS  = PLRU_WAYS,
    parameter  int SETS  = PLRU_SETS,
    localparam int WAY_W = $clog2(WAYS),
    localparam int SET_W = $clog2(SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             acc_valid,
    output logic             acc_ready,
    input  logic [SET_W-1:0] acc_set,
    input  logic             acc_hit,
    input  logic [WAYS-1:0]  acc_hit_vec,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WAY_W-1:0] rsp_way,
    output logic             rsp_hit,
    output logic             rsp_err,
    output logic [31:0]      stat_hits,
    output logic [31:0]      stat_misses
);

    localparam int          NODES      = WAYS - 1;
    localparam int unsigned LEVELS     = WAY_W;
    localparam logic [SET_W-1:0] c_last_set = SET_W'(SETS - 1);

    plru_state_e               r_state;
    plru_state_e               w_state_nxt;
    logic [SET_W-1:0]          r_sweep;
    logic [NODES-1:0]          r_tree [SETS];

    logic                      r_rsp_valid;
    logic [WAY_W-1:0]          r_rsp_way;
    logic                      r_rsp_hit;
    logic                      r_rsp_err;

    logic                      w_acc_ready;
    logic                      w_accept;
    logic [WAY_W-1:0]          w_enc_idx;
    logic                      w_enc_err;
    logic                      w_hit_ok;
    logic                      w_bad_hit;
    logic [NODES-1:0]          w_tree_cur;
    logic [NODES-1:0]          w_tree_wr;
    logic [PLRU_MAX_NODES-1:0] w_tree_ext;
    logic [PLRU_MAX_NODES-1:0] w_tree_touched;
    logic [PLRU_MAX_WAY_W-1:0] w_victim_ext;
    logic [PLRU_MAX_WAY_W-1:0] w_touch_way_ext;
    logic [WAY_W-1:0]          w_victim;
    logic [WAY_W-1:0]          w_sel_way;

    onehot_encoder #(
        .WAYS (WAYS)
    ) u_enc (
        .vec  (acc_hit_vec),
        .idx  (w_enc_idx),
        .err  (w_enc_err)
    );

    assign w_hit_ok  = acc_hit & ~w_enc_err;
    assign w_bad_hit = acc_hit &  w_enc_err;
    assign w_accept  = acc_valid & w_acc_ready;

    // Read and update the addressed set combinationally; write lands on the accept edge.
    assign w_tree_cur      = r_tree[acc_set];
    assign w_tree_ext      = PLRU_MAX_NODES'(w_tree_cur);
    assign w_victim_ext    = plru_victim(w_tree_ext, LEVELS);
    assign w_victim        = w_victim_ext[WAY_W-1:0];
    assign w_sel_way       = w_hit_ok ? w_enc_idx : w_victim;
    assign w_touch_way_ext = PLRU_MAX_WAY_W'(w_sel_way);
    assign w_tree_touched  = plru_touch(w_tree_ext, w_touch_way_ext, LEVELS);
    assign w_tree_wr       = w_tree_touched[NODES-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_ready = 1'b0;
        case (r_state)
            INIT: begin
                if (!flush && (r_sweep == c_last_set)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_acc_ready = !flush && (!r_rsp_valid || rsp_ready);
                if (flush) begin
                    w_state_nxt = INIT;
                end
            end
            default: w_state_nxt = INIT;
        endcase
    end

    // A flush in either state restarts the sweep at set 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sweep <= '0;
        end else if (flush || (r_state != INIT) || (r_sweep == c_last_set)) begin
            r_sweep <= '0;
        end else begin
            r_sweep <= r_sweep + SET_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_tree[r_sweep] <= '0;
        end else if (w_accept && !w_bad_hit) begin
            r_tree[acc_set] <= w_tree_wr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_way   <= '0;
            r_rsp_hit   <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp_way   <= w_sel_way;
            r_rsp_hit   <= acc_hit;
            r_rsp_err   <= w_bad_hit;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign acc_ready = w_acc_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_way   = r_rsp_way;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_err   = r_rsp_err;

`ifdef PLRU_STATS_EN
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_misses;

    // Saturating counters; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_hits   <= '0;
            r_stat_misses <= '0;
        end else if (w_accept) begin
            if (w_hit_ok && (r_stat_hits != '1)) begin
                r_stat_hits <= r_stat_hits + 32'd1;
            end
            if (!w_hit_ok && (r_stat_misses != '1)) begin
                r_stat_misses <= r_stat_misses + 32'd1;
            end
        end
    end

    assign stat_hits   = r_stat_hits;
    assign stat_misses = r_stat_misses;
`else
    assign stat_hits   = 32'd0;
    assign stat_misses = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_plru_way_selector.sv
`default_nettype none
// ============================================================================
// Module : tb_plru_way_selector
// Brief  : Self-checking bench; reference model tracks last-touch times per way.
// Rev    : 1.0  initial release
// ============================================================================
module tb_plru_way_selector;

    localparam int WAYS  = 8;
    localparam int SETS  = 16;
    localparam int WAY_W = 3;
    localparam int SET_W = 4;

    logic             clk         = 1'b0;
    logic             rst_n       = 1'b0;
    logic             flush       = 1'b0;
    logic             acc_valid   = 1'b0;
    logic [SET_W-1:0] acc_set     = '0;
    logic             acc_hit     = 1'b0;
    logic [WAYS-1:0]  acc_hit_vec = '0;
    logic             rsp_ready   = 1'b1;
    logic             acc_ready;
    logic             rsp_valid;
    logic [WAY_W-1:0] rsp_way;
    logic             rsp_hit;
    logic             rsp_err;
    logic [31:0]      stat_hits;
    logic [31:0]      stat_misses;

    int nchecks  = 0;
    int nerrors  = 0;
    int ts [SETS][WAYS];
    int tick     = 0;
    int m_hits   = 0;
    int m_misses = 0;

    always #5 clk = ~clk;

    plru_way_selector #(
        .WAYS (WAYS),
        .SETS (SETS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .acc_valid   (acc_valid),
        .acc_ready   (acc_ready),
        .acc_set     (acc_set),
        .acc_hit     (acc_hit),
        .acc_hit_vec (acc_hit_vec),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_way     (rsp_way),
        .rsp_hit     (rsp_hit),
        .rsp_err     (rsp_err),
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // -1 means never touched since the last clear.
    function automatic void model_clear();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                ts[s][w] = -1;
    endfunction

    // Victim: descend into the half whose most recent touch is older (left on a tie).
    function automatic int model_victim(input int s);
        int lo, size, half, ml, mr;
        lo   = 0;
        size = WAYS;
        while (size > 1) begin
            half = size / 2;
            ml   = -1;
            mr   = -1;
            for (int i = 0; i < half; i++) begin
                if (ts[s][lo+i] > ml)      ml = ts[s][lo+i];
                if (ts[s][lo+half+i] > mr) mr = ts[s][lo+half+i];
            end
            if (mr < ml) lo = lo + half;
            size = half;
        end
        return lo;
    endfunction

    function automatic void model_touch(input int s, input int w);
        tick++;
        ts[s][w] = tick;
    endfunction

    task automatic access(input int s, input bit hit, input logic [WAYS-1:0] vec,
                          input int lit, input string tag);
        int exp_way;
        bit exp_err;
        int wcnt;
        exp_err = hit && ($countones(vec) != 1);
        exp_way = 0;
        if (hit && !exp_err) begin
            for (int i = 0; i < WAYS; i++)
                if (vec[i]) exp_way = i;
        end else begin
            exp_way = model_victim(s);
        end
        acc_valid   = 1'b1;
        acc_set     = SET_W'(s);
        acc_hit     = hit;
        acc_hit_vec = vec;
        wcnt = 0;
        while (!acc_ready && wcnt < 50) begin
            @(negedge clk);
            wcnt++;
        end
        if (wcnt >= 50) check({tag, "_ready_timeout"}, acc_ready, 1);
        @(posedge clk);
        @(negedge clk);
        acc_valid = 1'b0;
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_way"},   rsp_way,   exp_way);
        check({tag, "_hit"},   rsp_hit,   hit);
        check({tag, "_err"},   rsp_err,   exp_err);
        if (lit >= 0) check({tag, "_way_lit"}, rsp_way, lit);
        if (hit && !exp_err) m_hits++;
        else                 m_misses++;
        if (!exp_err) model_touch(s, exp_way);
    endtask

    task automatic count_init(input string tag);
        int cnt;
        cnt = 0;
        while (!acc_ready && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check(tag, cnt, SETS);
    endtask

    initial begin
        int seq [9];
        int s, kind, exp_b;
        logic [WAYS-1:0] v;
        seq = '{0, 4, 2, 6, 1, 5, 3, 7, 0};
        model_clear();

        repeat (3) @(negedge clk);
        check("rst_acc_ready", acc_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_way",   rsp_way,   0);
        check("rst_rsp_hit",   rsp_hit,   0);
        check("rst_rsp_err",   rsp_err,   0);
        check("rst_stat_hits", stat_hits, 0);
        check("rst_stat_miss", stat_misses, 0);
        rst_n = 1'b1;
        #1;
        count_init("init_len");

        access(3, 0, '0, 0, "first_miss_s3");
        for (int i = 0; i < 9; i++) access(5, 0, '0, seq[i], "miss_seq_s5");

        access(2, 0, '0,       0, "s2_miss");
        access(2, 1, 8'h10,    4, "s2_hit");
        access(2, 0, '0,       2, "s2_miss2");

        access(7, 1, 8'h00,    0, "err_zero");
        access(7, 1, 8'h06,    0, "err_multi");
        access(7, 0, '0,       0, "err_nochange");

        // Backpressure: second access must stall until the response drains.
        @(negedge clk);
        rsp_ready = 1'b0;
        access(9, 0, '0, 0, "bp_first");
        exp_b       = model_victim(9);
        acc_valid   = 1'b1;
        acc_set     = SET_W'(9);
        acc_hit     = 1'b0;
        acc_hit_vec = '0;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready_low",  acc_ready, 0);
            check("bp_way_stable", rsp_way,   0);
            check("bp_valid_held", rsp_valid, 1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", acc_ready, 1);
        @(posedge clk);
        @(negedge clk);
        acc_valid = 1'b0;
        check("bp_second_valid", rsp_valid, 1);
        check("bp_second_way",   rsp_way,   exp_b);
        model_touch(9, exp_b);
        m_misses++;

        // Flush with a pending response and a competing access.
        @(negedge clk);
        rsp_ready = 1'b0;
        access(4, 0, '0, 0, "fl_pending");
        acc_valid   = 1'b1;
        acc_set     = SET_W'(4);
        acc_hit     = 1'b0;
        acc_hit_vec = '0;
        flush       = 1'b1;
        #1;
        check("fl_ready_low", acc_ready, 0);
        @(posedge clk);
        @(negedge clk);
        flush     = 1'b0;
        acc_valid = 1'b0;
        check("fl_rsp_kept", rsp_valid, 1);
        check("fl_rsp_way",  rsp_way,   0);
        rsp_ready = 1'b1;
        model_clear();
        count_init("fl_init_len");
        check("fl_delivered", rsp_valid, 0);
        access(4, 0, '0, 0, "fl_after_miss");

        for (int i = 0; i < 300; i++) begin
            s    = $urandom_range(0, SETS-1);
            kind = $urandom_range(0, 9);
            v    = '0;
            if (kind >= 4 && kind < 9) v[$urandom_range(0, WAYS-1)] = 1'b1;
            else if (kind == 9)        v = WAYS'($urandom);
            access(s, kind >= 4, v, -1, "rand");
        end

`ifdef PLRU_STATS_EN
        check("stat_hits",   stat_hits,   m_hits);
        check("stat_misses", stat_misses, m_misses);
`else
        check("stat_hits_tied",   stat_hits,   0);
        check("stat_misses_tied", stat_misses, 0);
`endif

        // Asynchronous reset with a response pending drops it immediately.
        @(negedge clk);
        rsp_ready = 1'b0;
        access(6, 0, '0, -1, "rst_pending");
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", rsp_valid,   0);
        check("midrst_acc_ready", acc_ready,   0);
        check("midrst_rsp_way",   rsp_way,     0);
        check("midrst_stat_hits", stat_hits,   0);
        check("midrst_stat_miss", stat_misses, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #1;
        model_clear();
        count_init("midrst_init_len");
        access(6, 0, '0, 0, "midrst_after_miss");

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
`default_nettype wire
